// File: rtl/trace_pkg.sv
// Shared constants for the trigger-based trace capture buffer.
// State encoding and pointer-width helper.
package trace_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_POSTTRIG = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Sample storage for trace_capture.
// One synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Circular capture buffer: triggers on the first even sample, keeps POST
// more samples, freezes, then drains oldest-first over valid/ready.
module trace_capture
    import trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int POST  = 8,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [1:0]       state,
    output logic             triggered,
    output logic [AW-1:0]    trig_pos,
    output logic [AW:0]      count
);

    localparam int PW = AW + 1;
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] POST_V = PW'(POST);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] post_cnt;
    logic          do_arm;
    logic          do_wr;
    logic          trig;
    logic          rd_fire;

    always_comb begin
        do_arm  = arm && (state != ST_DONE);
        do_wr   = in_valid && !do_arm &&
                  ((state == ST_ARMED) || (state == ST_POSTTRIG));
        trig    = do_wr && (state == ST_ARMED) && !in_data[0];
        rd_valid = (state == ST_DONE) && (count != '0);
        rd_fire = rd_valid && rd_ready;
        // Oldest entry sits count slots behind the write pointer.
        rd_ptr  = wr_ptr - count[AW-1:0];
    end

    trace_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            triggered <= 1'b0;
            trig_pos  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            post_cnt  <= '0;
        end else if (do_arm) begin
            state     <= ST_ARMED;
            triggered <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            post_cnt  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != FULL) begin
                    count <= count + 1'b1;
                end
            end
            if (trig) begin
                trig_pos  <= wr_ptr;
                triggered <= 1'b1;
                post_cnt  <= '0;
                state     <= (POST == 0) ? ST_DONE : ST_POSTTRIG;
            end
            if (do_wr && (state == ST_POSTTRIG)) begin
                post_cnt <= post_cnt + 1'b1;
                if (post_cnt + 1'b1 == POST_V) begin
                    state <= ST_DONE;
                end
            end
            if (rd_fire) begin
                count <= count - 1'b1;
                if (count == (AW + 1)'(1)) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule
